spi_slave_core: RTL

- SPI responder (slave) core: the far end of the link driven by the team's APB4 SPI master.
- Oversamples the external SCK/NSS/MOSI in the system clock domain and shifts DATA_WIDTH-bit words in and out.
- Exposes valid/ready TX and RX word interfaces to a local register block, plus sticky overrun/underrun flags.
- Intended for loopback benches against the master and as the device-side front end of SPI-attached peripherals.

---
 rtl/spi_slave_core.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/spi_slave_core.sv
// spi_slave_core: SPI responder core. SCK, NSS and MOSI are oversampled in
// the clk_i domain. DATA_WIDTH-bit words are shifted in and out, with
// valid/ready TX and RX word interfaces and sticky overrun/underrun flags.
// Optional feature: define SPI_SLAVE_LSB_FIRST_EN to add lsb_first_i, which
// selects LSB-first bit order per word.
module spi_slave_core #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter bit          CPOL       = 1'b0,
  parameter bit          CPHA       = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  spi_sck_i,
  input  logic                  spi_nss_i,
  input  logic                  spi_mosi_i,
  output logic                  spi_miso_o,
  output logic                  spi_miso_en_o,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  input  logic                  tx_valid_i,
  output logic                  tx_ready_o,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  rx_valid_o,
  input  logic                  rx_ready_i,
  output logic                  busy_o,
  output logic                  ovr_o,
  output logic                  undr_o,
  input  logic                  flag_clr_i
`ifdef SPI_SLAVE_LSB_FIRST_EN
  ,
  input  logic                  lsb_first_i
`endif
);

  localparam int unsigned CntW = $clog2(DATA_WIDTH + 1);
  localparam logic [CntW-1:0] WordEnd = CntW'(DATA_WIDTH);
  localparam logic [CntW-1:0] LastBit = CntW'(DATA_WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e state_q, state_d;

  logic sck_s1_q, sck_s2_q, sck_s3_q;
  logic nss_s1_q, nss_s2_q, nss_s3_q;
  logic mosi_s1_q, mosi_s2_q;

  logic [CntW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_tx_q, shift_tx_d;
  logic [DATA_WIDTH-1:0] shift_rx_q, shift_rx_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  tx_ready_q, tx_ready_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  miso_en_q, miso_en_d;
  logic                  busy_q, busy_d;
  logic                  ovr_q, ovr_d;
  logic                  undr_q, undr_d;

  logic sck_rise_c, sck_fall_c, lead_c, trail_c, sample_c, shift_c;
  logic nss_fall_c, nss_rise_c;
  logic load_c, commit_c, ovr_set_c, undr_set_c;
  logic lsb_load_c, lsb_mode_c;
  logic [DATA_WIDTH-1:0] load_val_c, word_c;

  function automatic logic [DATA_WIDTH-1:0] bit_rev(input logic [DATA_WIDTH-1:0] v);
    logic [DATA_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < int'(DATA_WIDTH); i++) r[i] = v[DATA_WIDTH-1-i];
    return r;
  endfunction

  // Pin synchronisers; the third SCK/NSS stage feeds edge detection.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sck_s1_q  <= CPOL;
      sck_s2_q  <= CPOL;
      sck_s3_q  <= CPOL;
      nss_s1_q  <= 1'b1;
      nss_s2_q  <= 1'b1;
      nss_s3_q  <= 1'b1;
      mosi_s1_q <= 1'b0;
      mosi_s2_q <= 1'b0;
    end else begin
      sck_s1_q  <= spi_sck_i;
      sck_s2_q  <= sck_s1_q;
      sck_s3_q  <= sck_s2_q;
      nss_s1_q  <= spi_nss_i;
      nss_s2_q  <= nss_s1_q;
      nss_s3_q  <= nss_s2_q;
      mosi_s1_q <= spi_mosi_i;
      mosi_s2_q <= mosi_s1_q;
    end
  end

  assign sck_rise_c = sck_s2_q & ~sck_s3_q;
  assign sck_fall_c = ~sck_s2_q & sck_s3_q;
  assign lead_c     = CPOL ? sck_fall_c : sck_rise_c;
  assign trail_c    = CPOL ? sck_rise_c : sck_fall_c;
  assign sample_c   = CPHA ? trail_c : lead_c;
  assign shift_c    = CPHA ? lead_c : trail_c;
  assign nss_fall_c = ~nss_s2_q & nss_s3_q;
  assign nss_rise_c = nss_s2_q & ~nss_s3_q;

  // Next-state logic: transfer FSM, shift registers, handshakes and flags.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_tx_d = shift_tx_q;
    shift_rx_d = shift_rx_q;
    hold_d     = hold_q;
    tx_ready_d = tx_ready_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    miso_en_d  = miso_en_q;
    busy_d     = ~nss_s2_q;
    ovr_d      = ovr_q;
    undr_d     = undr_q;
    load_c     = 1'b0;
    commit_c   = 1'b0;
    ovr_set_c  = 1'b0;
    undr_set_c = 1'b0;
    word_c     = {shift_rx_q[DATA_WIDTH-2:0], mosi_s2_q};
    load_val_c = tx_ready_q ? '0 : hold_q;

    case (state_q)
      IDLE: begin
        if (nss_fall_c) begin
          state_d   = SHIFT;
          load_c    = 1'b1;
          bit_cnt_d = '0;
          miso_en_d = 1'b1;
        end
      end
      SHIFT: begin
        if (nss_rise_c) begin
          // Abort: drop partial word and line drive, holding register kept.
          state_d    = IDLE;
          bit_cnt_d  = '0;
          shift_tx_d = '0;
          shift_rx_d = '0;
          miso_en_d  = 1'b0;
        end else if (sample_c && bit_cnt_q != WordEnd) begin
          shift_rx_d = word_c;
          bit_cnt_d  = bit_cnt_q + CntW'(1);
          if (bit_cnt_q == LastBit) begin
            if (!rx_valid_q || rx_ready_i) commit_c  = 1'b1;
            else                           ovr_set_c = 1'b1;
          end
        end else if (shift_c) begin
          if (bit_cnt_q == WordEnd) begin
            load_c    = 1'b1;
            bit_cnt_d = '0;
          end else if (bit_cnt_q != '0) begin
            shift_tx_d = {shift_tx_q[DATA_WIDTH-2:0], 1'b0};
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A load takes the old holding contents; a same-cycle capture refills it.
    if (load_c) begin
      shift_tx_d = lsb_load_c ? bit_rev(load_val_c) : load_val_c;
      undr_set_c = tx_ready_q;
      tx_ready_d = 1'b1;
    end
    if (tx_valid_i && tx_ready_q) begin
      hold_d     = tx_data_i;
      tx_ready_d = 1'b0;
    end

    if (rx_valid_q && rx_ready_i) rx_valid_d = 1'b0;
    if (commit_c) begin
      rx_data_d  = lsb_mode_c ? bit_rev(word_c) : word_c;
      rx_valid_d = 1'b1;
    end

    if (flag_clr_i) begin
      ovr_d  = 1'b0;
      undr_d = 1'b0;
    end
    if (ovr_set_c)  ovr_d  = 1'b1;
    if (undr_set_c) undr_d = 1'b1;
  end

  // State and datapath registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_tx_q <= '0;
      shift_rx_q <= '0;
      hold_q     <= '0;
      tx_ready_q <= 1'b1;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      miso_en_q  <= 1'b0;
      busy_q     <= 1'b0;
      ovr_q      <= 1'b0;
      undr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_tx_q <= shift_tx_d;
      shift_rx_q <= shift_rx_d;
      hold_q     <= hold_d;
      tx_ready_q <= tx_ready_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      miso_en_q  <= miso_en_d;
      busy_q     <= busy_d;
      ovr_q      <= ovr_d;
      undr_q     <= undr_d;
    end
  end

`ifdef SPI_SLAVE_LSB_FIRST_EN
  logic lsb_q, lsb_d;

  assign lsb_load_c = lsb_first_i;
  assign lsb_mode_c = lsb_q;
  assign lsb_d      = load_c ? lsb_first_i : lsb_q;

  // Bit order is latched per word so RX assembly matches the TX load.
  always_ff @(posedge clk_i) begin
    if (rst_i) lsb_q <= 1'b0;
    else       lsb_q <= lsb_d;
  end
`else
  assign lsb_load_c = 1'b0;
  assign lsb_mode_c = 1'b0;
`endif

  assign spi_miso_o    = miso_en_q & shift_tx_q[DATA_WIDTH-1];
  assign spi_miso_en_o = miso_en_q;
  assign tx_ready_o    = tx_ready_q;
  assign rx_data_o     = rx_data_q;
  assign rx_valid_o    = rx_valid_q;
  assign busy_o        = busy_q;
  assign ovr_o         = ovr_q;
  assign undr_o        = undr_q;

endmodule
